matmul_controller: RTL and testbench
====================================

MATMUL_CONTROLLER -- requirements
Module: matmul_controller

Interface
- REQ-001: Parameter In_W, default 8: element width in bits (two's complement).
- REQ-002: Parameter In_D_Add_W, default 4: buffer address width.
- REQ-003: Parameter In_Items, default 6: vector length N, 1 <= N <= 2^In_D_Add_W.
- REQ-004: Parameter RD_LAT, default 1: buffer read latency in cycles, 1 or 2.
- REQ-005: clk  in  1: single clock; all logic rising-edge.
- REQ-006: rst  in  1: asynchronous, active-low reset.
- REQ-007: start  in  1: request a load-and-compute run; sampled in IDLE only.
- REQ-008: load_valid  in  1 / load_ready  out  1: load-beat handshake; a beat transfers when both are high.
- REQ-009: load_row, load_col  in  In_W each: row and column elements of the current beat.
- REQ-010: ena_r, wea_r, ena_c, wea_c  out  1 each: write-port enables of the row and column buffers.
- REQ-011: addra_r, addra_c  out  In_D_Add_W: write addresses. din_r, din_c  out  In_W: write data.
- REQ-012: enb_r, enb_c  out  1 / addrb_r, addrb_c  out  In_D_Add_W: read enables and read addresses.
- REQ-013: clr, en_MAC, en_MAC_out  out  1 each: MAC accumulator clear, accumulate enable and output-register enable.
- REQ-014: busy  out  1: high in every state except IDLE. done  out  1: one-cycle pulse; the MAC result is valid on this cycle.

Function
- REQ-015: States are IDLE, LOAD, CLEAR, READ, DRAIN, OUT and DONE, encoded as an enum.
- REQ-016: IDLE -> LOAD when start=1; otherwise the FSM stays in IDLE.
- REQ-017: LOAD holds load_ready=1 and transfers one beat per handshake.
  - On each transfer, the beat is written at address wr_cnt: ena_*=wea_*=1, din_r=load_row, din_c=load_col, addra_*=wr_cnt.
  - wr_cnt then increments.
  - Gaps in load_valid stall the FSM with no write.
- REQ-018: The FSM goes LOAD -> CLEAR on the transfer of beat N-1; load_ready is 0 in every state other than LOAD.
- REQ-019: CLEAR lasts 1 cycle with clr=1 and en_MAC=0.
- REQ-020: READ lasts exactly N cycles with enb_*=1 and addrb_*=rd_cnt, where rd_cnt runs 0..N-1. Row and column buffers are read with the same address.
- REQ-021: en_MAC equals the read-enable delayed by RD_LAT cycles, so it is high for exactly N cycles aligned with buffer output data.
- REQ-022: DRAIN lasts RD_LAT cycles; READ -> DRAIN -> OUT.
- REQ-023: OUT lasts 1 cycle with en_MAC_out=1. DONE lasts 1 cycle with done=1, then returns to IDLE.
- REQ-024: Timing, with CLEAR at cycle t:
  - reads occur at t+1..t+N;
  - en_MAC is high at t+1+RD_LAT..t+N+RD_LAT;
  - en_MAC_out is high at t+N+RD_LAT+1;
  - done is high at t+N+RD_LAT+2.
- REQ-025: start is ignored while busy=1. load_valid is ignored outside LOAD.
- REQ-026: Counters are In_D_Add_W+1 bits wide; addresses never exceed N-1 and never wrap within a run.
- REQ-027: wr_cnt and rd_cnt clear on entry to LOAD and to CLEAR respectively, so back-to-back runs need no reset.
- REQ-028: Write-port and read-port strobes are never both active on the same address in the same cycle.

Reset
- REQ-029: While rst=0, the FSM is in IDLE and all outputs and counters are 0, including load_ready, busy, done, clr, en_MAC, en_MAC_out and the delay line.
- REQ-030: Reset asserted mid-run aborts the run immediately, with no done pulse; after release the FSM waits in IDLE for a new start.

Structure
- REQ-031: Package matmul_ctrl_pkg holds the state enum, the default parameter values and the counter-width function.
- REQ-032: Sub-module ctrl_delay_line, a RD_LAT-deep 1-bit shift register with async active-low reset, generates en_MAC.

Verification
- REQ-033: Default parameters; row=1..6, col=all 1, continuous valid -> 6 writes at addresses 0..5, en_MAC high 6 cycles, done at t+9, y=21.
- REQ-034: row=all -128, col=all -128 -> y=98304 with no overflow, i.e. 18-bit signed.
- REQ-035: load_valid gaps of 0..3 cycles between beats -> writes occur only on handshake cycles; the result is identical to REQ-033.
- REQ-036: start pulsed during READ -> ignored; exactly one done pulse. A second run with row=2, col=3 -> y=36, showing clr worked.
- REQ-037: rst=0 at READ cycle 3 -> all outputs 0 within the same cycle, no done pulse; a clean run afterwards still gives y=21.
- REQ-038: RD_LAT=2, N=1, row=5, col=-7 -> en_MAC high 1 cycle at t+3, en_MAC_out at t+4, done at t+5, y=-35.

Source files
------------

// File: rtl/matmul_ctrl_pkg.sv
// Shared types and defaults for the matrix-multiply MAC controller.
// Holds the FSM state encoding, default parameter values and the counter-width helper.
package matmul_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CLEAR = 3'd2,
    READ  = 3'd3,
    DRAIN = 3'd4,
    OUT   = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam int DEF_IN_W       = 8;
  localparam int DEF_IN_D_ADD_W = 4;
  localparam int DEF_IN_ITEMS   = 6;
  localparam int DEF_RD_LAT     = 1;

  // One extra bit so a counter can represent N itself when N = 2^addr_w.
  function automatic int cnt_w(input int add_w);
    return add_w + 1;
  endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// DEPTH-stage 1-bit shift register; realigns the buffer read enable with
// the buffer output data to form the MAC accumulate enable.
module ctrl_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] stage_reg;
  logic [DEPTH-1:0] stage_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_next[gi] = din;
      end else begin : g_tail
        assign stage_next[gi] = stage_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= stage_next;
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/matmul_controller.sv
// Load-then-compute controller for a dot-product MAC: streams N row/column
// beats into two buffers, then reads them back in lockstep to drive the MAC.
module matmul_controller
  import matmul_ctrl_pkg::*;
#(
  parameter int In_W       = DEF_IN_W,
  parameter int In_D_Add_W = DEF_IN_D_ADD_W,
  parameter int In_Items   = DEF_IN_ITEMS,
  parameter int RD_LAT     = DEF_RD_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [In_W-1:0]       load_row,
  input  logic [In_W-1:0]       load_col,
  output logic                  ena_r,
  output logic                  wea_r,
  output logic                  ena_c,
  output logic                  wea_c,
  output logic [In_D_Add_W-1:0] addra_r,
  output logic [In_D_Add_W-1:0] addra_c,
  output logic [In_W-1:0]       din_r,
  output logic [In_W-1:0]       din_c,
  output logic                  enb_r,
  output logic                  enb_c,
  output logic [In_D_Add_W-1:0] addrb_r,
  output logic [In_D_Add_W-1:0] addrb_c,
  output logic                  clr,
  output logic                  en_MAC,
  output logic                  en_MAC_out,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = cnt_w(In_D_Add_W);
  localparam logic [CW-1:0] LAST_IDX = CW'(In_Items - 1);
  localparam logic [1:0]    LAST_DLY = 2'(RD_LAT - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] wr_cnt_reg, wr_cnt_next;
  logic [CW-1:0] rd_cnt_reg, rd_cnt_next;
  logic [1:0]    dly_cnt_reg, dly_cnt_next;
  logic          wr_fire;
  logic          rd_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      wr_cnt_reg  <= '0;
      rd_cnt_reg  <= '0;
      dly_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      wr_cnt_reg  <= wr_cnt_next;
      rd_cnt_reg  <= rd_cnt_next;
      dly_cnt_reg <= dly_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    wr_cnt_next  = wr_cnt_reg;
    rd_cnt_next  = rd_cnt_reg;
    dly_cnt_next = dly_cnt_reg;
    load_ready   = 1'b0;
    wr_fire      = 1'b0;
    rd_en        = 1'b0;
    clr          = 1'b0;
    en_MAC_out   = 1'b0;
    done         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next  = LOAD;
          wr_cnt_next = '0;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        wr_fire    = load_valid;
        if (load_valid) begin
          wr_cnt_next = wr_cnt_reg + 1'b1;
          if (wr_cnt_reg == LAST_IDX) begin
            state_next  = CLEAR;
            rd_cnt_next = '0;
          end
        end
      end
      CLEAR: begin
        clr        = 1'b1;
        state_next = READ;
      end
      READ: begin
        rd_en       = 1'b1;
        rd_cnt_next = rd_cnt_reg + 1'b1;
        if (rd_cnt_reg == LAST_IDX) begin
          state_next   = DRAIN;
          dly_cnt_next = '0;
        end
      end
      DRAIN: begin
        // Wait out the buffer latency so the final product reaches the accumulator.
        dly_cnt_next = dly_cnt_reg + 1'b1;
        if (dly_cnt_reg == LAST_DLY) begin
          state_next = OUT;
        end
      end
      OUT: begin
        en_MAC_out = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state_reg != IDLE);

  // Ports are zeroed when idle so nothing stray reaches the buffers.
  assign ena_r   = wr_fire;
  assign wea_r   = wr_fire;
  assign ena_c   = wr_fire;
  assign wea_c   = wr_fire;
  assign addra_r = wr_fire ? wr_cnt_reg[In_D_Add_W-1:0] : '0;
  assign addra_c = wr_fire ? wr_cnt_reg[In_D_Add_W-1:0] : '0;
  assign din_r   = wr_fire ? load_row : '0;
  assign din_c   = wr_fire ? load_col : '0;

  assign enb_r   = rd_en;
  assign enb_c   = rd_en;
  assign addrb_r = rd_en ? rd_cnt_reg[In_D_Add_W-1:0] : '0;
  assign addrb_c = rd_en ? rd_cnt_reg[In_D_Add_W-1:0] : '0;

  ctrl_delay_line #(
    .DEPTH(RD_LAT)
  ) u_mac_dly (
    .clk (clk),
    .rst (rst),
    .din (rd_en),
    .dout(en_MAC)
  );

endmodule

// File: tb/tb_matmul_controller.sv
// Scoreboard bench: behavioural buffers and MAC around two controller instances
// (default parameters, and N=1 with two-cycle read latency).
module tb_matmul_controller;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always_ff @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A: defaults (N=6, RD_LAT=1)
  logic       start_a, load_valid_a, load_ready_a;
  logic [7:0] load_row_a, load_col_a, din_r_a, din_c_a;
  logic       ena_r_a, wea_r_a, ena_c_a, wea_c_a, enb_r_a, enb_c_a;
  logic [3:0] addra_r_a, addra_c_a, addrb_r_a, addrb_c_a;
  logic       clr_a, en_MAC_a, en_MAC_out_a, busy_a, done_a;

  matmul_controller dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .load_valid(load_valid_a), .load_ready(load_ready_a),
    .load_row(load_row_a), .load_col(load_col_a),
    .ena_r(ena_r_a), .wea_r(wea_r_a), .ena_c(ena_c_a), .wea_c(wea_c_a),
    .addra_r(addra_r_a), .addra_c(addra_c_a), .din_r(din_r_a), .din_c(din_c_a),
    .enb_r(enb_r_a), .enb_c(enb_c_a), .addrb_r(addrb_r_a), .addrb_c(addrb_c_a),
    .clr(clr_a), .en_MAC(en_MAC_a), .en_MAC_out(en_MAC_out_a),
    .busy(busy_a), .done(done_a)
  );

  // ---------------- instance B: N=1, RD_LAT=2
  logic       start_b, load_valid_b, load_ready_b;
  logic [7:0] load_row_b, load_col_b, din_r_b, din_c_b;
  logic       ena_r_b, wea_r_b, ena_c_b, wea_c_b, enb_r_b, enb_c_b;
  logic [3:0] addra_r_b, addra_c_b, addrb_r_b, addrb_c_b;
  logic       clr_b, en_MAC_b, en_MAC_out_b, busy_b, done_b;

  matmul_controller #(.In_Items(1), .RD_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .load_valid(load_valid_b), .load_ready(load_ready_b),
    .load_row(load_row_b), .load_col(load_col_b),
    .ena_r(ena_r_b), .wea_r(wea_r_b), .ena_c(ena_c_b), .wea_c(wea_c_b),
    .addra_r(addra_r_b), .addra_c(addra_c_b), .din_r(din_r_b), .din_c(din_c_b),
    .enb_r(enb_r_b), .enb_c(enb_c_b), .addrb_r(addrb_r_b), .addrb_c(addrb_c_b),
    .clr(clr_b), .en_MAC(en_MAC_b), .en_MAC_out(en_MAC_out_b),
    .busy(busy_b), .done(done_b)
  );

  // ---------------- buffer + MAC models
  logic [7:0]         mem_r_a [16];
  logic [7:0]         mem_c_a [16];
  logic [7:0]         q_r_a, q_c_a;
  logic signed [15:0] prod_a;
  logic signed [23:0] acc_a, y_a;
  assign prod_a = $signed(q_r_a) * $signed(q_c_a);

  always_ff @(posedge clk) begin
    if (ena_r_a && wea_r_a) mem_r_a[addra_r_a] <= din_r_a;
    if (ena_c_a && wea_c_a) mem_c_a[addra_c_a] <= din_c_a;
    if (enb_r_a) q_r_a <= mem_r_a[addrb_r_a];
    if (enb_c_a) q_c_a <= mem_c_a[addrb_c_a];
    if (clr_a) acc_a <= '0;
    else if (en_MAC_a) acc_a <= acc_a + 24'(prod_a);
    if (en_MAC_out_a) y_a <= acc_a;
  end

  logic [7:0]         mem_r_b [16];
  logic [7:0]         mem_c_b [16];
  logic [7:0]         q1_r_b, q1_c_b, q2_r_b, q2_c_b;
  logic signed [15:0] prod_b;
  logic signed [23:0] acc_b, y_b;
  assign prod_b = $signed(q2_r_b) * $signed(q2_c_b);

  always_ff @(posedge clk) begin
    if (ena_r_b && wea_r_b) mem_r_b[addra_r_b] <= din_r_b;
    if (ena_c_b && wea_c_b) mem_c_b[addra_c_b] <= din_c_b;
    if (enb_r_b) q1_r_b <= mem_r_b[addrb_r_b];
    if (enb_c_b) q1_c_b <= mem_c_b[addrb_c_b];
    q2_r_b <= q1_r_b;
    q2_c_b <= q1_c_b;
    if (clr_b) acc_b <= '0;
    else if (en_MAC_b) acc_b <= acc_b + 24'(prod_b);
    if (en_MAC_out_b) y_b <= acc_b;
  end

  // ---------------- checking
  int sb_a[$];
  int sb_b[$];
  int done_cnt_a = 0, done_cnt_b = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor A: write handshakes, schedule relative to CLEAR, result on done.
  initial begin
    int t_clr, en_cnt, wr_idx;
    t_clr = 0; en_cnt = 0; wr_idx = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        en_cnt = 0; wr_idx = 0;
      end else begin
        if (ena_r_a) begin
          check("a_wr_handshake", int'(load_valid_a && load_ready_a), 1);
          check("a_wr_addr", int'(addra_r_a), wr_idx);
          check("a_wr_din", int'(din_c_a), int'(load_col_a));
          wr_idx++;
        end
        if (ena_r_a || enb_r_a) check("a_port_overlap", int'(ena_r_a && enb_r_a), 0);
        if (clr_a) begin
          check("a_wr_count", wr_idx, 6);
          t_clr = cyc; en_cnt = 0; wr_idx = 0;
        end
        if (en_MAC_a) begin
          if (en_cnt == 0) check("a_enmac_start", cyc - t_clr, 2);
          en_cnt++;
        end
        if (en_MAC_out_a) begin
          check("a_out_time", cyc - t_clr, 8);
          check("a_enmac_len", en_cnt, 6);
        end
        if (done_a) begin
          done_cnt_a++;
          check("a_done_time", cyc - t_clr, 9);
          if (sb_a.size() == 0) check("a_unexpected_done", 1, 0);
          else begin
            int exp_y;
            exp_y = sb_a.pop_front();
            check("a_result_y", int'(y_a), exp_y);
            $display("A run %0d: y=%0d expected %0d", done_cnt_a, int'(y_a), exp_y);
          end
        end
      end
    end
  end

  initial begin
    int t_clr, en_cnt;
    t_clr = 0; en_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) en_cnt = 0;
      else begin
        if (ena_r_b) check("b_wr_addr", int'(addra_r_b), 0);
        if (clr_b) begin t_clr = cyc; en_cnt = 0; end
        if (en_MAC_b) begin
          if (en_cnt == 0) check("b_enmac_start", cyc - t_clr, 3);
          en_cnt++;
        end
        if (en_MAC_out_b) begin
          check("b_out_time", cyc - t_clr, 4);
          check("b_enmac_len", en_cnt, 1);
        end
        if (done_b) begin
          done_cnt_b++;
          check("b_done_time", cyc - t_clr, 5);
          if (sb_b.size() == 0) check("b_unexpected_done", 1, 0);
          else begin
            int exp_y;
            exp_y = sb_b.pop_front();
            check("b_result_y", int'(y_b), exp_y);
            $display("B run %0d: y=%0d expected %0d", done_cnt_b, int'(y_b), exp_y);
          end
        end
      end
    end
  end

  function automatic int outs_a_any();
    return int'(|{load_ready_a, ena_r_a, wea_r_a, ena_c_a, wea_c_a, addra_r_a, addra_c_a,
                  din_r_a, din_c_a, enb_r_a, enb_c_a, addrb_r_a, addrb_c_a,
                  clr_a, en_MAC_a, en_MAC_out_a, busy_a, done_a});
  endfunction

  function automatic int outs_b_any();
    return int'(|{load_ready_b, ena_r_b, wea_r_b, ena_c_b, wea_c_b, addra_r_b, addra_c_b,
                  din_r_b, din_c_b, enb_r_b, enb_c_b, addrb_r_b, addrb_c_b,
                  clr_b, en_MAC_b, en_MAC_out_b, busy_b, done_b});
  endfunction

  // mode 0: plain run; 1: pulse start during READ; 2: reset at READ cycle 3
  task automatic run_a(input int row[6], input int col[6], input int gap[6],
                       input int exp_y, input int mode);
    int  dc0, w;
    bit  poked;
    if (mode != 2) sb_a.push_back(exp_y);
    dc0 = done_cnt_a;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load_valid_a = 1'b0;
      repeat (gap[i]) begin @(posedge clk); #1; end
      load_valid_a = 1'b1;
      load_row_a = 8'(row[i]);
      load_col_a = 8'(col[i]);
      w = 0;
      while (!load_ready_a && w < 20) begin @(posedge clk); #1; w++; end
      if (w >= 20) check("a_load_ready_timeout", 0, 1);
      @(posedge clk); #1;
    end
    load_valid_a = 1'b0; load_row_a = '0; load_col_a = '0;
    w = 0; poked = 1'b0;
    while (done_cnt_a == dc0 && w < 100) begin
      if (mode == 2 && enb_r_a && addrb_r_a == 4'd2) begin
        rst = 1'b0;
        #1;
        check("a_abort_outputs_zero", outs_a_any(), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("a_abort_no_done", done_cnt_a - dc0, 0);
        check("a_abort_idle", int'(busy_a), 0);
        return;
      end
      if (mode == 1 && enb_r_a && !poked) begin
        start_a = 1'b1; poked = 1'b1;
      end else begin
        start_a = 1'b0;
      end
      @(posedge clk); #1;
      w++;
    end
    start_a = 1'b0;
    if (done_cnt_a == dc0) check("a_done_timeout", 0, 1);
    repeat (4) @(posedge clk);
    #1;
    check("a_single_done", done_cnt_a - dc0, 1);
    check("a_idle_after", int'(busy_a), 0);
  endtask

  initial begin
    int ones[6]  = '{1, 1, 1, 1, 1, 1};
    int seq[6]   = '{1, 2, 3, 4, 5, 6};
    int neg[6]   = '{-128, -128, -128, -128, -128, -128};
    int twos[6]  = '{2, 2, 2, 2, 2, 2};
    int threes[6]= '{3, 3, 3, 3, 3, 3};
    int nogap[6] = '{0, 0, 0, 0, 0, 0};
    int gaps[6]  = '{1, 0, 2, 3, 1, 2};
    int dc0, w;

    rst = 1'b0;
    start_a = 0; load_valid_a = 0; load_row_a = 0; load_col_a = 0;
    start_b = 0; load_valid_b = 0; load_row_b = 0; load_col_b = 0;
    start_a = 1'b1;  // must have no effect while held in reset
    repeat (3) @(posedge clk);
    #1;
    check("a_reset_outputs", outs_a_any(), 0);
    check("b_reset_outputs", outs_b_any(), 0);
    start_a = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("a_idle_no_start", int'(busy_a), 0);

    run_a(seq, ones, nogap, 21, 0);
    run_a(neg, neg, nogap, 98304, 0);
    run_a(seq, ones, gaps, 21, 0);
    run_a(seq, ones, nogap, 21, 1);
    run_a(twos, threes, nogap, 36, 0);
    run_a(seq, ones, nogap, 0, 2);
    run_a(seq, ones, nogap, 21, 0);

    // instance B: single beat, two-cycle read latency
    sb_b.push_back(-35);
    dc0 = done_cnt_b;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    load_valid_b = 1'b1; load_row_b = 8'd5; load_col_b = 8'hF9;
    check("b_load_ready", int'(load_ready_b), 1);
    @(posedge clk); #1;
    load_valid_b = 1'b0;
    w = 0;
    while (done_cnt_b == dc0 && w < 50) begin @(posedge clk); #1; w++; end
    if (done_cnt_b == dc0) check("b_done_timeout", 0, 1);

    repeat (3) @(posedge clk);
    #1;
    check("a_total_done", done_cnt_a, 6);
    check("b_total_done", done_cnt_b, 1);
    check("a_scoreboard_empty", sb_a.size(), 0);
    check("b_scoreboard_empty", sb_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
